// File: rtl/key_conditioner_if.sv
// Key bundle between the panel pins and the key conditioner.
// master: drives key_raw, sees the conditioned outputs; slave: the conditioner.
interface key_conditioner_if #(
    parameter int N_KEYS = 5
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_pos;
    logic [N_KEYS-1:0] key_neg;
    logic [N_KEYS-1:0] key_long;
    logic              any_activity;

    modport master (
        output key_raw,
        input  key_level, key_pos, key_neg, key_long, any_activity
    );

    modport slave (
        input  key_raw,
        output key_level, key_pos, key_neg, key_long, any_activity
    );
endinterface

// File: rtl/key_conditioner.sv
// Per-key 2-FF sync, debounce FSM, press/release/long-press pulse generation.
// Ports: clk, rst (sync, active-high); kif.slave: key_raw in; key_level,
// key_pos, key_neg, key_long, any_activity out (all registered).
module key_conditioner #(
    parameter int N_KEYS      = 5,
    parameter int DB_CYCLES   = 2_000_000,
    parameter int LONG_CYCLES = 300_000_000
) (
    input logic              clk,
    input logic              rst,
    key_conditioner_if.slave kif
);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int HW  = $clog2(LONG_CYCLES + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [DBW-1:0] DB_FULL   = DBW'(DB_CYCLES);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_FULL = HW'(LONG_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        LONG,
        RELEASE_WAIT
    } state_t;

    logic [N_KEYS-1:0] level_n, pos_n, neg_n, long_n;
    logic [N_KEYS-1:0] level_q, pos_q, neg_q, long_q;
    logic              act_q;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        state_t         state_q, state_d;
        logic [DBW-1:0] db_q, db_d, db_inc;
        logic [HW-1:0]  hold_q, hold_d, hold_inc;
        logic           ret_long_q, ret_long_d;
        logic           sync1_q, sync2_q;
        logic           db_hit, hold_hit, long_fire;
        logic           lvl_d, pos_d, neg_d, long_d;

        // db_q is 0 whenever a wait starts, so db_hit in IDLE/HELD/LONG
        // means the very first sample already completes the debounce.
        assign db_inc   = (db_q == DB_FULL) ? db_q : db_q + 1'b1;
        assign hold_inc = (hold_q == HOLD_FULL) ? hold_q : hold_q + 1'b1;
        assign db_hit   = (db_q == DB_LAST);
        assign hold_hit = (hold_q == HOLD_LAST);

        // Long press still pending while held or bouncing out of HELD.
        assign long_fire = hold_hit &&
            ((state_q == HELD) ||
             ((state_q == RELEASE_WAIT) && !ret_long_q));

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                state_q    <= IDLE;
                db_q       <= '0;
                hold_q     <= '0;
                ret_long_q <= 1'b0;
            end else begin
                sync1_q    <= kif.key_raw[k];
                sync2_q    <= sync1_q;
                state_q    <= state_d;
                db_q       <= db_d;
                hold_q     <= hold_d;
                ret_long_q <= ret_long_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            db_d       = db_q;
            hold_d     = hold_q;
            ret_long_d = ret_long_q;
            pos_d      = 1'b0;
            neg_d      = 1'b0;
            long_d     = long_fire;
            unique case (state_q)
                IDLE, PRESS_WAIT: begin
                    if (!sync2_q) begin
                        state_d = IDLE;
                        db_d    = '0;
                    end else if (db_hit) begin
                        state_d    = HELD;
                        db_d       = '0;
                        hold_d     = '0;
                        ret_long_d = 1'b0;
                        pos_d      = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                        db_d    = db_inc;
                    end
                end
                HELD, LONG, RELEASE_WAIT: begin
                    if (state_q != LONG) begin
                        hold_d = hold_inc;
                    end
                    if (state_q != RELEASE_WAIT) begin
                        ret_long_d = (state_q == LONG) || long_fire;
                    end else if (long_fire) begin
                        ret_long_d = 1'b1;
                    end
                    if (sync2_q) begin
                        db_d    = '0;
                        state_d = ret_long_d ? LONG : HELD;
                    end else if (db_hit) begin
                        state_d    = IDLE;
                        db_d       = '0;
                        hold_d     = '0;
                        ret_long_d = 1'b0;
                        neg_d      = 1'b1;
                    end else begin
                        state_d = RELEASE_WAIT;
                        db_d    = db_inc;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    db_d       = '0;
                    hold_d     = '0;
                    ret_long_d = 1'b0;
                    long_d     = 1'b0;
                end
            endcase
            lvl_d = (state_d == HELD) || (state_d == LONG) ||
                    (state_d == RELEASE_WAIT);
        end

        assign level_n[k] = lvl_d;
        assign pos_n[k]   = pos_d;
        assign neg_n[k]   = neg_d;
        assign long_n[k]  = long_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
            long_q  <= '0;
            act_q   <= 1'b0;
        end else begin
            level_q <= level_n;
            pos_q   <= pos_n;
            neg_q   <= neg_n;
            long_q  <= long_n;
            act_q   <= |pos_n;
        end
    end

    assign kif.key_level    = level_q;
    assign kif.key_pos      = pos_q;
    assign kif.key_neg      = neg_q;
    assign kif.key_long     = long_q;
    assign kif.any_activity = act_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed latency checks plus random key traffic
// compared each cycle against a sample-history model of the debounce rules.
module tb_key_conditioner;
    localparam int N  = 5;
    localparam int DB = 4;
    localparam int LC = 10;
    localparam int W_LVL  = 0;
    localparam int W_POS  = 1;
    localparam int W_NEG  = 2;
    localparam int W_LONG = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_conditioner_if #(.N_KEYS(N)) kif ();

    key_conditioner #(
        .N_KEYS     (N),
        .DB_CYCLES  (DB),
        .LONG_CYCLES(LC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kif(kif)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cnt_pos[N];
    int cnt_neg[N];
    int cnt_long[N];

    // Model: raw -> two-sample delay; level flips after DB consecutive
    // samples disagreeing with it; long fires LC edges after the press
    // edge if the level was still high going into that edge.
    bit m_valid = 1'b0;
    bit m_s1[N], m_s2[N], m_lvl[N], m_fired[N];
    int m_run[N], m_since[N];
    bit m_smp;
    logic [N-1:0] e_lvl, e_pos, e_neg, e_long;
    logic         e_act;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_valid = 1'b1;
            for (int k = 0; k < N; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_fired[k] = 0;
                m_run[k] = 0; m_since[k] = 0;
            end
            e_lvl = '0; e_pos = '0; e_neg = '0; e_long = '0; e_act = 1'b0;
        end else if (m_valid) begin
            for (int k = 0; k < N; k++) begin
                m_smp   = m_s2[k];
                m_s2[k] = m_s1[k];
                m_s1[k] = kif.key_raw[k];
                e_pos[k] = 1'b0; e_neg[k] = 1'b0; e_long[k] = 1'b0;
                if (m_lvl[k] && !m_fired[k]) begin
                    m_since[k]++;
                    if (m_since[k] == LC) begin
                        e_long[k]  = 1'b1;
                        m_fired[k] = 1;
                    end
                end
                if (m_smp != m_lvl[k]) m_run[k]++;
                else m_run[k] = 0;
                if (m_run[k] == DB) begin
                    m_lvl[k] = !m_lvl[k];
                    m_run[k] = 0;
                    if (m_lvl[k]) begin
                        e_pos[k]   = 1'b1;
                        m_since[k] = 0;
                        m_fired[k] = 0;
                    end else begin
                        e_neg[k] = 1'b1;
                    end
                end
                e_lvl[k] = m_lvl[k];
            end
            e_act = |e_pos;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if (kif.key_level !== e_lvl || kif.key_pos !== e_pos ||
                kif.key_neg !== e_neg || kif.key_long !== e_long ||
                kif.any_activity !== e_act) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t got lvl=%b pos=%b neg=%b long=%b act=%b exp lvl=%b pos=%b neg=%b long=%b act=%b",
                         $time, kif.key_level, kif.key_pos, kif.key_neg,
                         kif.key_long, kif.any_activity,
                         e_lvl, e_pos, e_neg, e_long, e_act);
            end
            for (int k = 0; k < N; k++) begin
                if (kif.key_pos[k] === 1'b1) cnt_pos[k]++;
                if (kif.key_neg[k] === 1'b1) cnt_neg[k]++;
                if (kif.key_long[k] === 1'b1) cnt_long[k]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [N-1:0] sel(input int w);
        case (w)
            W_LVL:   return kif.key_level;
            W_POS:   return kif.key_pos;
            W_NEG:   return kif.key_neg;
            default: return kif.key_long;
        endcase
    endfunction

    // n = number of edges until the pulse (first edge = 1), -1 on timeout.
    task automatic wait_evt(input int w, input int b, input int maxc,
                            output int n);
        logic [N-1:0] v;
        n = -1;
        for (int i = 1; i <= maxc && n < 0; i++) begin
            tick();
            v = sel(w);
            if (v[b] === 1'b1) n = i;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    initial begin
        int n, p0, pr;
        rst = 1'b1;
        kif.key_raw = '0;
        idle(3);
        check("reset_state", {kif.key_level, kif.key_pos, kif.key_neg,
              kif.key_long, kif.any_activity}, 0);
        rst = 1'b0;
        idle(3);

        // clean press / release on A
        kif.key_raw[0] = 1'b1;
        wait_evt(W_POS, 0, 20, n);
        check("t1_pos_latency", n, 6);
        check("t1_pos_vec", kif.key_pos, 5'b00001);
        check("t1_activity", kif.any_activity, 1);
        check("t1_level", kif.key_level, 5'b00001);
        tick();
        check("t1_pos_one_cycle", kif.key_pos, 0);
        kif.key_raw[0] = 1'b0;
        wait_evt(W_NEG, 0, 20, n);
        check("t1_neg_latency", n, 6);
        idle(4);

        // bounce on W
        p0 = cnt_pos[2];
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                kif.key_raw[2] = (j != 3);
                tick();
            end
        end
        kif.key_raw[2] = 1'b0;
        idle(3);
        check("t2_bounce_no_pos", cnt_pos[2], p0);
        kif.key_raw[2] = 1'b1;
        wait_evt(W_POS, 2, 20, n);
        check("t2_stable_pos_latency", n, 6);
        idle(2);
        check("t2_single_pos", cnt_pos[2], p0 + 1);
        kif.key_raw[2] = 1'b0;
        wait_evt(W_NEG, 2, 20, n);
        idle(4);

        // long press on X
        p0 = cnt_long[3];
        kif.key_raw[3] = 1'b1;
        wait_evt(W_POS, 3, 20, n);
        check("t3_pos_latency", n, 6);
        wait_evt(W_LONG, 3, 20, n);
        check("t3_long_after_pos", n, LC);
        idle(14);
        kif.key_raw[3] = 1'b0;
        wait_evt(W_NEG, 3, 20, n);
        check("t3_neg_latency", n, 6);
        idle(2);
        check("t3_long_once", cnt_long[3], p0 + 1);
        idle(3);

        // short press on S, then a one-cycle glitch while held
        p0 = cnt_long[1];
        kif.key_raw[1] = 1'b1;
        idle(8);
        kif.key_raw[1] = 1'b0;
        wait_evt(W_NEG, 1, 20, n);
        check("t4_short_neg_latency", n, 6);
        idle(2);
        check("t4_short_no_long", cnt_long[1], p0);
        p0 = cnt_neg[1];
        kif.key_raw[1] = 1'b1;
        wait_evt(W_POS, 1, 20, n);
        idle(2);
        kif.key_raw[1] = 1'b0;
        tick();
        kif.key_raw[1] = 1'b1;
        idle(8);
        check("t4_glitch_level", kif.key_level[1], 1);
        check("t4_glitch_no_neg", cnt_neg[1], p0);
        kif.key_raw[1] = 1'b0;
        wait_evt(W_NEG, 1, 20, n);
        idle(3);

        // simultaneous A and D
        kif.key_raw = 5'b10001;
        wait_evt(W_POS, 0, 20, n);
        check("t5_pos_latency", n, 6);
        check("t5_pos_vec", kif.key_pos, 5'b10001);
        check("t5_activity", kif.any_activity, 1);
        tick();
        check("t5_activity_one_cycle", kif.any_activity, 0);
        kif.key_raw = '0;
        wait_evt(W_NEG, 0, 20, n);
        idle(3);

        // reset mid-debounce of A while D is already accepted
        kif.key_raw[4] = 1'b1;
        wait_evt(W_POS, 4, 20, n);
        kif.key_raw[0] = 1'b1;
        idle(3);
        rst = 1'b1;
        tick();
        check("t6_outputs_in_reset", {kif.key_level, kif.key_pos,
              kif.key_neg, kif.key_long, kif.any_activity}, 0);
        rst = 1'b0;
        wait_evt(W_POS, 0, 20, n);
        check("t6_pos_after_reset", n, DB + 2);
        check("t6_pos_vec", kif.key_pos, 5'b10001);
        kif.key_raw = '0;
        idle(10);

        // random traffic with occasional resets
        for (int seg = 0; seg < 15; seg++) begin
            case ($urandom_range(2))
                0:       pr = 3;
                1:       pr = 8;
                default: pr = 30;
            endcase
            for (int c = 0; c < 200; c++) begin
                for (int k = 0; k < N; k++) begin
                    if ($urandom_range(pr - 1) == 0)
                        kif.key_raw[k] = ~kif.key_raw[k];
                end
                rst = ($urandom_range(299) == 0);
                tick();
            end
        end
        rst = 1'b0;
        kif.key_raw = '0;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
